uart_rx_64: RTL and testbench

UART_RX_64 -- requirements
Module: uart_rx_64

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_byte.sv | 106 ++++++++++
 rtl/uart_rx_64.sv | 123 ++++++++++++
 tb/tb_uart_rx_64.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit sides.
//   rx_state_e   - byte-level receiver FSM encoding
//   clks_per_bit - system clocks per serial bit (integer division)
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: receives one 8N1 character from an asynchronous line.
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   rxd         - raw serial input (idle high)
//   rx_byte     - received character, LSB was first on the line
//   byte_valid  - strobe: stop bit sampled high, rx_byte is good
//   stop_err    - strobe: stop bit sampled low, character discarded
//   state_dbg   - current FSM state (rx_state_e encoding)
// Strobe semantics: byte_valid and stop_err are single-cycle, mutually
// exclusive, and have no back-pressure; the consumer must take rx_byte in
// the cycle the strobe is high. Both are raised in the stop-sample cycle.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       stop_err,
  output logic [1:0] state_dbg
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic          sync1_q, sync2_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    stop_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!sync2_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // Re-check the line at mid start bit to reject glitches.
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = sync2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        // Return to IDLE at mid stop bit so a back-to-back start is seen.
        if (cnt_q == LAST) begin
          cnt_d      = '0;
          state_d    = IDLE;
          byte_valid = sync2_q;
          stop_err   = !sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign rx_byte   = shift_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/uart_rx_64.sv
// uart_rx_64: assembles eight UART characters into a 64-bit word.
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   uart_rxd      - asynchronous serial line (idle high)
//   data_64       - last complete frame, first character in [63:56]
//   data_valid    - one-cycle strobe when data_64 is updated
//   frame_err     - one-cycle strobe on a bad stop bit
//   timeout_err   - one-cycle strobe when a partial frame is dropped
//   busy          - character or partial frame in progress
//   rx_state_dbg  - byte receiver FSM state, for observation
module uart_rx_64
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rxd,
  output logic [63:0] data_64,
  output logic        data_valid,
  output logic        frame_err,
  output logic        timeout_err,
  output logic        busy,
  output logic [1:0]  rx_state_dbg
);

  localparam int CPB = int'(clks_per_bit(CLK_FREQ, BAUD_RATE));
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_BITS * CPB - 1);

  logic [7:0]  rx_byte;
  logic        byte_valid, stop_err, byte_busy;

  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [55:0] frame_q, frame_d;
  logic [63:0] data_64_q, data_64_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        data_valid_q, data_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        timeout_err_q, timeout_err_d;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) u_byte (
    .clk        (clk),
    .rst        (rst),
    .rxd        (uart_rxd),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .stop_err   (stop_err),
    .state_dbg  (rx_state_dbg)
  );

  assign byte_busy = (rx_state_dbg != IDLE);

  always_comb begin
    byte_cnt_d    = byte_cnt_q;
    frame_d       = frame_q;
    data_64_d     = data_64_q;
    to_cnt_d      = to_cnt_q;
    data_valid_d  = 1'b0;
    frame_err_d   = 1'b0;
    timeout_err_d = 1'b0;

    // Idle-gap timer: only runs between characters of a partial frame.
    // A start detect moves the byte FSM out of IDLE, which clears it. On
    // expiry the count is cleared first, so a start in the same cycle
    // opens a fresh frame.
    if (byte_cnt_q != 3'd0 && !byte_busy) begin
      if (to_cnt_q == TO_LAST) begin
        timeout_err_d = 1'b1;
        byte_cnt_d    = 3'd0;
        to_cnt_d      = '0;
      end else begin
        to_cnt_d = to_cnt_q + 32'd1;
      end
    end else begin
      to_cnt_d = '0;
    end

    // Strobes only occur while the byte FSM is busy, so they never
    // coincide with a timeout.
    if (stop_err) begin
      frame_err_d = 1'b1;
      byte_cnt_d  = 3'd0;
    end else if (byte_valid) begin
      frame_d = {frame_q[47:0], rx_byte};
      if (byte_cnt_q == 3'd7) begin
        data_64_d    = {frame_q, rx_byte};
        data_valid_d = 1'b1;
        byte_cnt_d   = 3'd0;
      end else begin
        byte_cnt_d = byte_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q    <= 3'd0;
      frame_q       <= '0;
      data_64_q     <= 64'h0;
      to_cnt_q      <= '0;
      data_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      byte_cnt_q    <= byte_cnt_d;
      frame_q       <= frame_d;
      data_64_q     <= data_64_d;
      to_cnt_q      <= to_cnt_d;
      data_valid_q  <= data_valid_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign data_64     = data_64_q;
  assign data_valid  = data_valid_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;
  assign busy        = byte_busy || (byte_cnt_q != 3'd0);

endmodule

// File: tb/tb_uart_rx_64.sv
// tb_uart_rx_64: self-checking bench for uart_rx_64.
// The bit rate is scaled to 16 clocks per bit so the whole run stays short;
// the line glitch is scaled accordingly to stay below half a bit period.
module tb_uart_rx_64;

  localparam int CLK_FREQ     = 1_600_000;
  localparam int BAUD_RATE    = 100_000;
  localparam int TIMEOUT_BITS = 16;
  localparam int CPB          = CLK_FREQ / BAUD_RATE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rxd = 1'b1;
  logic [63:0] data_64;
  logic        data_valid, frame_err, timeout_err, busy;
  logic [1:0]  rx_state_dbg;

  uart_rx_64 #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD_RATE    (BAUD_RATE),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rxd     (uart_rxd),
    .data_64      (data_64),
    .data_valid   (data_valid),
    .frame_err    (frame_err),
    .timeout_err  (timeout_err),
    .busy         (busy),
    .rx_state_dbg (rx_state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  part_q[$];
  logic [63:0] model_last = 64'h0;
  int          exp_ferr = 0, got_ferr = 0;
  int          exp_to = 0, got_to = 0;
  bit          in_reset = 1'b1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    uart_rxd = v;
    repeat (CPB) tick();
  endtask

  // Model update happens before the stop bit, i.e. ahead of the DUT strobe.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [63:0] f;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (stop) begin
      part_q.push_back(b);
      if (part_q.size() == 8) begin
        f = '0;
        foreach (part_q[k]) f = {f[55:0], part_q[k]};
        exp_q.push_back(f);
        part_q.delete();
      end
    end else begin
      exp_ferr++;
      part_q.delete();
    end
    drive_bit(stop);
    uart_rxd = 1'b1;
  endtask

  task automatic line_idle(input int nbits);
    uart_rxd = 1'b1;
    repeat (nbits * CPB) tick();
    if (nbits >= TIMEOUT_BITS + 2 && part_q.size() != 0) begin
      exp_to++;
      part_q.delete();
    end
  endtask

  task automatic send_frame(input logic [63:0] v, input int gap);
    for (int i = 0; i < 8; i++) begin
      send_byte(v[63-8*i -: 8], 1'b1);
      if (i < 7) line_idle(gap);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20 * CPB) begin
      tick();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_counts(input string name);
    check({name, "_ferr"}, 64'(got_ferr), 64'(exp_ferr));
    check({name, "_tout"}, 64'(got_to), 64'(exp_to));
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_data"}, data_64, 64'h0);
    check({name, "_dv"}, 64'(data_valid), 64'd0);
    check({name, "_ferr"}, 64'(frame_err), 64'd0);
    check({name, "_tout"}, 64'(timeout_err), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    in_reset   = 1'b1;
    model_last = 64'h0;
    part_q.delete();
    uart_rxd   = 1'b1;
    rst        = 1'b1;
    repeat (3) tick();
    check_reset_values("mid_reset");
    rst = 1'b0;
    tick();
    in_reset = 1'b0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!in_reset) begin
      if (data_valid || frame_err || timeout_err)
        check("pulse_exclusive",
              64'(int'(data_valid) + int'(frame_err) + int'(timeout_err)), 64'd1);
      if (frame_err) got_ferr++;
      if (timeout_err) got_to++;
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL data_valid_unexpected: got %h expected no pulse", data_64);
        end else begin
          model_last = exp_q.pop_front();
          check("frame_data", data_64, model_last);
        end
      end else begin
        check("data_hold", data_64, model_last);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] v;
    int          r;
    bit          after_err;

    repeat (4) tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();
    in_reset = 1'b0;
    line_idle(2);

    // Known frame, literal pin on the model.
    send_frame(64'h81A34D6FF6B2C581, 1);
    line_idle(2);
    drain("t1_drain");
    check("t1_literal", data_64, 64'h81A34D6FF6B2C581);
    check_counts("t1");

    // Short low glitch: rejected as a false start.
    uart_rxd = 1'b0;
    repeat (CPB / 2 - 2) tick();
    uart_rxd = 1'b1;
    line_idle(2);
    check("t2_busy", 64'(busy), 64'd0);
    check("t2_data", data_64, 64'h81A34D6FF6B2C581);
    check_counts("t2");

    // Bad stop bit on byte 3, then a good frame.
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    line_idle(2);
    check("t3_ferr_literal", 64'(got_ferr), 64'd1);
    check("t3_data_kept", data_64, 64'h81A34D6FF6B2C581);
    check("t3_busy", 64'(busy), 64'd0);
    send_frame(64'h0123456789ABCDEF, 2);
    line_idle(2);
    drain("t3_drain");
    check("t3_literal", data_64, 64'h0123456789ABCDEF);
    check_counts("t3");

    // Three bytes then a long gap: partial frame dropped.
    send_byte(8'hA1, 1'b1);
    send_byte(8'hA2, 1'b1);
    send_byte(8'hA3, 1'b1);
    check("t4_busy_partial", 64'(busy), 64'd1);
    line_idle(20);
    check("t4_tout_literal", 64'(got_to), 64'd1);
    check("t4_busy_after", 64'(busy), 64'd0);
    v = {$urandom, $urandom};
    send_frame(v, 0);
    line_idle(2);
    drain("t4_drain");
    check("t4_frame", data_64, v);
    check_counts("t4");

    // Two frames back to back, no gap anywhere.
    send_frame(64'hDEADBEEFCAFEF00D, 0);
    send_frame(64'h5A5AA5A5F00FF00F, 0);
    line_idle(2);
    drain("t5_drain");
    check("t5_literal", data_64, 64'h5A5AA5A5F00FF00F);

    // Reset in the middle of byte 5.
    for (int i = 0; i < 4; i++) send_byte(8'(8'h40 + i), 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    do_reset();
    check_reset_values("post_reset");
    line_idle(2);
    send_frame(64'hFEDCBA9876543210, 1);
    line_idle(2);
    drain("t6_drain");
    check("t6_literal", data_64, 64'hFEDCBA9876543210);
    check_counts("t6");

    // Randomized traffic: random data, gaps, stop errors and timeouts.
    after_err = 1'b0;
    for (int n = 0; n < 56; n++) begin
      r = int'($urandom_range(0, 15));
      if (r == 1) line_idle(20);
      else if (after_err) line_idle(2);
      else line_idle(int'($urandom_range(0, TIMEOUT_BITS - 4)));
      after_err = (r == 0);
      send_byte(8'($urandom), (r != 0));
    end
    line_idle(20);
    drain("rand_drain");
    check_counts("rand");
    check("final_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
